// File: rtl/rr_share_arb_if.sv
// Bus bundle for rr_share_arb: requester-side request/grant/response signals
// plus the start/done handshake to the shared worker.
// slave  : the arbiter's view.
// master : the view of the environment driving requests and the worker.
interface rr_share_arb_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   rsp_y;
    logic           err;
    logic           busy;
    logic           res_start;
    logic [W-1:0]   res_x;
    logic           res_done;
    logic [W-1:0]   res_y;

    modport slave (
        input  req, req_x, res_done, res_y,
        output gnt, done, rsp_y, err, busy, res_start, res_x
    );

    modport master (
        output req, req_x, res_done, res_y,
        input  gnt, done, rsp_y, err, busy, res_start, res_x
    );
endinterface

// File: rtl/rr_share_arb.sv
// rr_share_arb: round-robin arbiter that shares one multi-cycle worker
// between N requesters, running one transaction at a time
// (grant, issue, wait, retire).
// Optional build macro RR_SHARE_ARB_TIMEOUT_EN adds a WAIT timeout that
// retires the transaction with err=1 after TIMEOUT cycles without res_done.
module rr_share_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    rr_share_arb_if.slave   bus
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    // Elaboration-time parameter range checks.
    if (N < 1 || N > 16) begin : g_bad_n
        $error("rr_share_arb: N out of range 1..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_share_arb: TIMEOUT out of range 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RETIRE = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [PW-1:0]  ptr_q,       ptr_d;
    logic [PW-1:0]  owner_q,     owner_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic [N-1:0]   done_q,      done_d;
    logic [W-1:0]   rsp_y_q,     rsp_y_d;
    logic           busy_q,      busy_d;
    logic           res_start_q, res_start_d;
    logic [W-1:0]   res_x_q,     res_x_d;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
    logic           err_q,       err_d;
    logic [7:0]     cnt_q,       cnt_d;
`endif

    logic [PW-1:0]  sel_c;
    logic           sel_vld_c;
    logic [PW-1:0]  ptr_next_c;

    // Pick the first requesting index starting at ptr, wrapping past N-1.
    always_comb begin
        int unsigned idx;
        sel_c     = '0;
        sel_vld_c = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!sel_vld_c && bus.req[idx]) begin
                sel_vld_c = 1'b1;
                sel_c     = PW'(idx);
            end
        end
    end

    // Pointer value after the current owner retires: owner+1 mod N.
    always_comb begin
        ptr_next_c = '0;
        if (owner_q != PW'(N - 1)) begin
            ptr_next_c = owner_q + PW'(1);
        end
    end

    // Transaction sequencer: next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rsp_y_d     = rsp_y_q;
        busy_d      = busy_q;
        res_start_d = 1'b0;
        res_x_d     = res_x_q;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
        err_d       = 1'b0;
        cnt_d       = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (sel_vld_c) begin
                    gnt_d       = N'(1) << sel_c;
                    owner_d     = sel_c;
                    res_start_d = 1'b1;
                    res_x_d     = bus.req_x[32'(sel_c) * W +: W];
                    busy_d      = 1'b1;
                    state_d     = S_WAIT;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end

            S_WAIT: begin
                // res_done is ignored in the cycle that carries res_start.
                if (!res_start_q && bus.res_done) begin
                    rsp_y_d = bus.res_y;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next_c;
                    state_d = S_RETIRE;
                end
`ifdef RR_SHARE_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next_c;
                    state_d = S_RETIRE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
`endif
            end

            S_RETIRE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rsp_y_q     <= '0;
            busy_q      <= 1'b0;
            res_start_q <= 1'b0;
            res_x_q     <= '0;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rsp_y_q     <= rsp_y_d;
            busy_q      <= busy_d;
            res_start_q <= res_start_d;
            res_x_q     <= res_x_d;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.busy      = busy_q;
    assign bus.res_start = res_start_q;
    assign bus.res_x     = res_x_q;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_rr_share_arb.sv
// Testbench for rr_share_arb: a driver acts as requesters and worker and
// pushes expected start/done events into queues; a negedge monitor pops them
// and compares against the DUT outputs.
module tb_rr_share_arb;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        int           cyc;
        logic [N-1:0] oh;
        logic [W-1:0] val;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t sq[$];
    exp_t dq[$];
    exp_t mon_e;
    logic [W-1:0] cur_x = '0;
    logic [N-1:0] cur_oh = '0;

    int           mptr = 0;
    logic [W-1:0] last_y = '0;

    rr_share_arb_if #(.N(N), .W(W)) bus ();

    rr_share_arb #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Round-robin reference: first set bit at p, p+1, ... wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < int'(N); i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Monitor: pops expectations whenever the DUT issues a start or a done.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_start) begin
                if (sq.size() == 0) begin
                    chk("unexpected_start", 64'(bus.gnt), 64'(0));
                end else begin
                    mon_e = sq.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("start_gnt", 64'(bus.gnt), 64'(mon_e.oh));
                    chk("start_res_x", 64'(bus.res_x), 64'(mon_e.val));
                    chk("start_busy", 64'(bus.busy), 64'(1));
                    cur_x  = mon_e.val;
                    cur_oh = mon_e.oh;
                end
            end else if (bus.busy) begin
                chk("wait_res_x_hold", 64'(bus.res_x), 64'(cur_x));
                chk("wait_gnt_hold", 64'(bus.gnt), 64'(cur_oh));
            end
            if (!bus.busy) chk("idle_gnt_zero", 64'(bus.gnt), 64'(0));
            if (bus.done != '0 || bus.err) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    mon_e = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("done_vec", 64'(bus.done), 64'(mon_e.oh));
                    chk("done_rsp_y", 64'(bus.rsp_y), 64'(mon_e.val));
                    chk("done_err", 64'(bus.err), 64'(mon_e.e));
                    chk("done_busy", 64'(bus.busy), 64'(0));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.res_done = 1'b0;
        @(posedge clk); #1;
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rsp_y", 64'(bus.rsp_y), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_res_start", 64'(bus.res_start), 64'(0));
        chk("rst_res_x", 64'(bus.res_x), 64'(0));
        rst = 1'b0;
        mptr = 0;
        last_y = '0;
        sq.delete();
        dq.delete();
    endtask

    task automatic idle(input int n);
        bus.req = '0;
        for (int i = 0; i < n; i++) begin
            bus.res_done = 1'($urandom);
            bus.res_y = W'($urandom);
            @(posedge clk); #1;
        end
        bus.res_done = 1'b0;
    endtask

    // One transaction, called in a cycle where the arbiter is IDLE.
    // wmode: 0 hold req in WAIT, 1 drop req, 2 randomise req/req_x.
    task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] xv, input int lat,
                       input logic [W-1:0] y, input int wmode, input bit spur);
        int   sel;
        int   s;
        exp_t e;
        bus.req = r;
        bus.req_x = xv;
        sel = pick(r, mptr);
        s = cyc + 1;
        e.cyc = s;
        e.oh  = N'(1) << sel;
        e.val = xv[sel*W +: W];
        e.e   = 1'b0;
        sq.push_back(e);
        e.cyc = s + lat + 1;
        e.val = y;
        dq.push_back(e);
        mptr = (sel + 1) % N;
        last_y = y;
        @(posedge clk); #1;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (wmode == 1) bus.req = '0;
            if (wmode == 2) begin
                bus.req = N'($urandom);
                bus.req_x = (N*W)'({$urandom, $urandom});
            end
            bus.res_done = (k == lat) || (k == 0 && spur);
            bus.res_y = (k == lat) ? y : W'($urandom);
        end
        @(posedge clk); #1;
        bus.res_done = spur;
        bus.res_y = W'($urandom);
        @(posedge clk); #1;
        bus.req = '0;
        chk("rsp_y_hold", 64'(bus.rsp_y), 64'(last_y));
    endtask

    initial begin
        logic [N*W-1:0] xv;
        exp_t e;
        int sel;
        int s;
        bus.req = '0;
        bus.req_x = '0;
        bus.res_done = 1'b0;
        bus.res_y = '0;
        do_reset();

        // Basic transaction on requester 1.
        xv = (N*W)'({$urandom, $urandom});
        xv[1*W +: W] = 8'h5A;
        txn(4'b0010, xv, 3, 8'hA5, 0, 1'b0);

        // All requesting: order 0,1,2,3,0,1,2,3 with spacing lat+3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            txn(4'b1111, (N*W)'({$urandom, $urandom}), 2, W'($urandom), 0, 1'b0);
        end

        // Requester 2 drops req after grant; pointer still advances to 3.
        txn(4'b0100, (N*W)'({$urandom, $urandom}), 3, W'($urandom), 1, 1'b0);
        txn(4'b1111, (N*W)'({$urandom, $urandom}), 1, W'($urandom), 0, 1'b0);

        // Spurious res_done with res_start, in RETIRE and in IDLE.
        txn(4'b1010, (N*W)'({$urandom, $urandom}), 4, W'($urandom), 0, 1'b1);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            txn(N'($urandom_range(1, 15)), (N*W)'({$urandom, $urandom}),
                $urandom_range(1, 6), W'($urandom), $urandom_range(0, 2),
                1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Reset mid-WAIT aborts; a later res_done is ignored; ptr restarts at 0.
        bus.req = 4'b0100;
        xv = (N*W)'({$urandom, $urandom});
        bus.req_x = xv;
        sel = pick(bus.req, mptr);
        e.cyc = cyc + 1;
        e.oh  = N'(1) << sel;
        e.val = xv[sel*W +: W];
        e.e   = 1'b0;
        sq.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset();
        bus.res_done = 1'b1;
        bus.res_y = 8'h33;
        @(posedge clk); #1;
        bus.res_done = 1'b0;
        chk("abort_no_done", 64'(bus.done), 64'(0));
        chk("abort_rsp_y", 64'(bus.rsp_y), 64'(0));
        txn(4'b1111, (N*W)'({$urandom, $urandom}), 2, W'($urandom), 0, 1'b0);

        // Worker never responds.
        bus.req = 4'b0001;
        xv = (N*W)'({$urandom, $urandom});
        bus.req_x = xv;
        sel = pick(bus.req, mptr);
        s = cyc + 1;
        e.cyc = s;
        e.oh  = N'(1) << sel;
        e.val = xv[sel*W +: W];
        e.e   = 1'b0;
        sq.push_back(e);
`ifdef RR_SHARE_ARB_TIMEOUT_EN
        e.cyc = s + 16;
        e.val = last_y;
        e.e   = 1'b1;
        dq.push_back(e);
        mptr = (sel + 1) % N;
`endif
        @(posedge clk); #1;
        bus.req = '0;
        bus.res_done = 1'b0;
`ifdef RR_SHARE_ARB_TIMEOUT_EN
        repeat (17) begin
            @(posedge clk); #1;
        end
        chk("timeout_idle_busy", 64'(bus.busy), 64'(0));
        bus.res_done = 1'b1;
        bus.res_y = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.res_done = 1'b0;
        chk("late_done_rsp_y", 64'(bus.rsp_y), 64'(last_y));
        txn(4'b1111, (N*W)'({$urandom, $urandom}), 2, W'($urandom), 0, 1'b0);
`else
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i % 10 == 9) chk("no_timeout_busy", 64'(bus.busy), 64'(1));
        end
        do_reset();
`endif

        idle(3);
        chk("start_queue_empty", 64'(sq.size()), 64'(0));
        chk("done_queue_empty", 64'(dq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
